// File: rtl/key_schedule_if.sv
// key_schedule_if
// Groups the request/response and read-port signals of the AES-128 key
// expander so the block and its users connect through one bundle.
//   master : drives start, key, rd_round; observes status, round keys, rd_key
//   slave  : the key_schedule block itself
// Signals:
//   start      request expansion of key (honoured only when idle)
//   key        cipher key, byte 0 in the top byte
//   busy       expansion in progress
//   done       one-cycle pulse once all round keys are stored
//   rk_valid   one-cycle pulse, round_key/rk_round carry a fresh round key
//   rk_round   index of the round key on round_key
//   round_key  freshly completed round key
//   rd_round   random-access read index
//   rd_key     stored round key rd_round (zero for indices past the last round)
interface key_schedule_if #(
  parameter int word_size  = 8,
  parameter int array_size = 16
);
  localparam int KEY_W = word_size * array_size;

  logic             start;
  logic [KEY_W-1:0] key;
  logic             busy;
  logic             done;
  logic             rk_valid;
  logic [3:0]       rk_round;
  logic [KEY_W-1:0] round_key;
  logic [3:0]       rd_round;
  logic [KEY_W-1:0] rd_key;

  modport master (
    output start, key, rd_round,
    input  busy, done, rk_valid, rk_round, round_key, rd_key
  );

  modport slave (
    input  start, key, rd_round,
    output busy, done, rk_valid, rk_round, round_key, rd_key
  );
endinterface

// File: rtl/key_schedule.sv
// key_schedule
// AES-128 key expansion, one 32-bit word per clock. A start in IDLE captures
// the cipher key as round 0; the next 40 cycles produce w4..w43, and every
// completed group of four words is announced on rk_valid/rk_round/round_key
// and written into an 11-entry round-key bank that downstream logic reads
// combinationally through rd_round/rd_key.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset; clears FSM, counter, bank and outputs
//   ks   key_schedule_if slave modport (start/key in, status and keys out)
module key_schedule #(
  parameter int word_size  = 8,
  parameter int array_size = 16
) (
  input  logic           clk,
  input  logic           rst,
  key_schedule_if.slave  ks
);

  localparam int KEY_W  = word_size * array_size;
  localparam int WORD_W = KEY_W / 4;
  localparam int ROUNDS = 11;

  // FIPS-197 S-box; packed [0:255] puts entry 0 in the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, FINISH} state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [5:0]          word_idx_reg;      // index i of the word computed this cycle
  logic [WORD_W-1:0]   win_reg [4];       // sliding window: w(i-4) .. w(i-1)
  logic [KEY_W-1:0]    bank_reg [ROUNDS];
  logic                rk_valid_reg;
  logic                done_reg;
  logic [3:0]          rk_round_reg;
  logic [KEY_W-1:0]    round_key_reg;
  logic                busy_next;

  logic [WORD_W-1:0]   key_word [4];
  logic [WORD_W-1:0]   rot_word;
  logic [WORD_W-1:0]   sub_word;
  logic [WORD_W-1:0]   temp_word;
  logic [WORD_W-1:0]   new_word;
  logic [KEY_W-1:0]    new_block;
  logic [7:0]          rcon;

  // Round constant for i/4 = 1..10, generated by repeated doubling in GF(2^8).
  always_comb begin
    rcon = 8'h00;
    case (word_idx_reg[5:2])
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // RotWord: rotate the newest word left by one byte.
  assign rot_word = {win_reg[3][WORD_W-word_size-1:0], win_reg[3][WORD_W-1 -: word_size]};

  // Split the incoming key into words (w0 in the top bits) and apply the
  // four parallel S-box lookups of SubWord.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
    assign key_word[gi] = ks.key[KEY_W-1-gi*WORD_W -: WORD_W];
    assign sub_word[gi*word_size +: word_size] = SBOX[rot_word[gi*word_size +: word_size]];
  end

  assign temp_word = (word_idx_reg[1:0] == 2'd0)
                   ? (sub_word ^ {rcon, {(WORD_W-8){1'b0}}})
                   : win_reg[3];
  assign new_word  = win_reg[0] ^ temp_word;

  // When i mod 4 = 3 this is the complete round key w(i-3)..w(i).
  assign new_block = {win_reg[1], win_reg[2], win_reg[3], new_word};

  // Next-state and status decode.
  always_comb begin
    state_next = state_reg;
    busy_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ks.start) state_next = EXPAND;
      end
      EXPAND: begin
        busy_next = 1'b1;
        if (word_idx_reg == 6'd43) state_next = FINISH;
      end
      FINISH: begin
        busy_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      word_idx_reg  <= '0;
      rk_valid_reg  <= 1'b0;
      done_reg      <= 1'b0;
      rk_round_reg  <= '0;
      round_key_reg <= '0;
      for (int r = 0; r < ROUNDS; r++) bank_reg[r] <= '0;
      for (int w = 0; w < 4; w++) win_reg[w] <= '0;
    end else begin
      state_reg     <= state_next;
      // Announcements are single-cycle pulses; outputs idle at zero.
      rk_valid_reg  <= 1'b0;
      done_reg      <= 1'b0;
      rk_round_reg  <= '0;
      round_key_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (ks.start) begin
            for (int w = 0; w < 4; w++) win_reg[w] <= key_word[w];
            bank_reg[0]   <= ks.key;
            word_idx_reg  <= 6'd4;
            rk_valid_reg  <= 1'b1;
            rk_round_reg  <= 4'd0;
            round_key_reg <= ks.key;
          end
        end
        EXPAND: begin
          win_reg[0]   <= win_reg[1];
          win_reg[1]   <= win_reg[2];
          win_reg[2]   <= win_reg[3];
          win_reg[3]   <= new_word;
          word_idx_reg <= word_idx_reg + 6'd1;
          if (word_idx_reg[1:0] == 2'd3) begin
            bank_reg[word_idx_reg[5:2]] <= new_block;
            rk_valid_reg  <= 1'b1;
            rk_round_reg  <= word_idx_reg[5:2];
            round_key_reg <= new_block;
          end
          // Last word: round 10 and done appear together in FINISH.
          if (word_idx_reg == 6'd43) done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ks.busy      = busy_next;
  assign ks.done      = done_reg;
  assign ks.rk_valid  = rk_valid_reg;
  assign ks.rk_round  = rk_round_reg;
  assign ks.round_key = round_key_reg;
  assign ks.rd_key    = (ks.rd_round < 4'd11) ? bank_reg[ks.rd_round] : '0;

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 Parameter: word_size, default 8, bits per byte.
REQ-002 Parameter: array_size, default 16, bytes per key/state block; only 8/16 supported.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  request expansion of key; sampled in IDLE only.
REQ-006 Port: key  input  128  AES-128 cipher key, FIPS-197 byte order, byte 0 = key[127:120].
REQ-007 Port: busy  output  1  expansion in progress.
REQ-008 Port: done  output  1  one-cycle pulse, all 11 round keys stored.
REQ-009 Port: rk_valid  output  1  one-cycle pulse, a new round key is complete.
REQ-010 Port: rk_round  output  4  round index 0..10 qualified by rk_valid.
REQ-011 Port: round_key  output  128  round key qualified by rk_valid, same byte order as key.
REQ-012 Port: rd_round  input  4  random-access read index for downstream AddRoundKey.
REQ-013 Port: rd_key  output  128  combinational read of stored round key rd_round.

Function
REQ-014 SHALL implement FSM states IDLE, EXPAND, FINISH; reset state IDLE.
REQ-015 SHALL, in IDLE with start=1 at cycle T, capture key as words w0..w3 and store it as round 0; enter EXPAND.
REQ-016 SHALL, in EXPAND, compute one word per cycle, w4..w43, word i written at end of cycle T+i-3.
REQ-017 SHALL compute wi = w(i-4) XOR temp; temp = SubWord(RotWord(w(i-1))) XOR Rcon(i/4) when i mod 4 = 0, else w(i-1).
REQ-018 SHALL use Rcon = 01,02,04,08,10,20,40,80,1b,36 (top byte, lower 24 bits zero) for i/4 = 1..10.
REQ-019 SHALL implement SubWord with the FIPS-197 S-box, 4 lookups in parallel, combinational.
REQ-020 SHALL assert rk_valid for exactly cycle T+4r+1 for round r = 0..10, with rk_round=r and round_key = {w4r..w4r+3}.
REQ-021 SHALL enter FINISH after w43; in cycle T+41 assert done=1 together with rk_valid for round 10; return to IDLE at T+42.
REQ-022 SHALL hold busy=1 for cycles T+1..T+41 inclusive, 0 otherwise.
REQ-023 SHALL ignore start while busy=1 (EXPAND or FINISH); key changes after T have no effect.
REQ-024 SHALL accept a new start in IDLE at T+42 or later; bank is overwritten round by round.
REQ-025 SHALL drive rk_round and round_key to 0 whenever rk_valid=0.
REQ-026 SHALL drive rd_key = stored round rd_round for rd_round 0..10, 0 for 11..15.
REQ-027 SHALL hold rd_key for round r valid from cycle T+4r+1 onward until overwritten by the next expansion.

Reset
REQ-028 SHALL, on rst=0 at any time including mid-expansion, immediately force IDLE, clear word counter, all 11 stored round keys, busy, done, rk_valid, rk_round, round_key to 0.
REQ-029 SHALL ignore start while rst=0; the first start is honoured on the first rising edge with rst=1.

Verification
REQ-030 FIPS-197 A.1: key=2b7e151628aed2a6abf7158809cf4f3c, start at T -> rk_valid at T+5, rk_round=1, round_key=a0fafe1788542cb123a339392a6c7605; at T+41 round_key=d014f9a8c9ee2589e13f0cc8b6630ca6, done=1.
REQ-031 All-zero key -> round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e; rd_round=0..10 after done matches all 11 rk_valid outputs, rd_round=12 -> 0.
REQ-032 Start asserted every cycle during an expansion, key toggled -> exactly 11 rk_valid pulses, one done, results equal the key captured at T.
REQ-033 rst=0 at T+20 -> busy, rk_valid, done, rd_key all 0 asynchronously; fresh start after release -> correct A.1 keys with no residue.
REQ-034 Back-to-back: start at T+42 with zero key after A.1 run -> rd_round=10 returns A.1 round 10 until T+83, zero-key round 10 from T+83.
REQ-035 Timing check: rk_valid high only at T+1, T+5, ..., T+41, rk_round incrementing 0..10, busy high exactly 41 cycles.
